// File: rtl/mpu_buffer_if.sv
// mpu_buffer_if: operand/result bundle for the mpu_buffer systolic MAC array.
//   a : N x DW  left-edge operands, one per row (driven by master)
//   b : N x DW  top-edge operands, one per column (driven by master)
//   c : N x N x OW  per-PE accumulators (driven by slave, registered)
// Modports: master = operand source / result consumer, slave = the array.
interface mpu_buffer_if #(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = 8,
    parameter int unsigned OW = 17
);
    logic [DW-1:0] a [0:N-1];
    logic [DW-1:0] b [0:N-1];
    logic [OW-1:0] c [0:N-1][0:N-1];

    modport master (output a, output b, input c);
    modport slave  (input a, input b, output c);
endinterface

// File: rtl/mpu_buffer.sv
// mpu_buffer: output-stationary N x N systolic multiply-accumulate array.
// Row operands enter on bus.a[i] and shift right one PE per cycle; column operands enter on
// bus.b[j] and shift down one PE per cycle. Each PE accumulates the product of the operands
// passing through it; bus.c[i][j] is that accumulator, straight from the register.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-low reset; clears operand pipes and accumulators
//   bus : mpu_buffer_if.slave (a, b in; c out)
// Build option: define MPU_BUFFER_SIGNED_EN for two's-complement int8 operands; default is
// unsigned. Accumulators wrap modulo 2^OW in both modes.
module mpu_buffer #(
    parameter int unsigned N  = 8,
    parameter int unsigned DW = 8,
    parameter int unsigned OW = 17
) (
    input  logic         clk,
    input  logic         rst,
    mpu_buffer_if.slave  bus
);

    logic [DW-1:0] a_q   [N][N];
    logic [DW-1:0] b_q   [N][N];
    logic [DW-1:0] a_in  [N][N];
    logic [DW-1:0] b_in  [N][N];
    logic [OW-1:0] acc_q [N][N];
    logic [OW-1:0] acc_d [N][N];

    // Full-width product extended to the accumulator width.
    function automatic logic [OW-1:0] ext_prod(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [2*DW-1:0] p;
`ifdef MPU_BUFFER_SIGNED_EN
        p = {{DW{x[DW-1]}}, x} * {{DW{y[DW-1]}}, y};
        return OW'($signed(p));
`else
        p = {{DW{1'b0}}, x} * {{DW{1'b0}}, y};
        return OW'(p);
`endif
    endfunction

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            a_in[i][0] = bus.a[i];
            for (int j = 1; j < int'(N); j++) begin
                a_in[i][j] = a_q[i][j-1];
            end
        end
        for (int j = 0; j < int'(N); j++) begin
            b_in[0][j] = bus.b[j];
            for (int i = 1; i < int'(N); i++) begin
                b_in[i][j] = b_q[i-1][j];
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                acc_d[i][j] = acc_q[i][j] + ext_prod(a_in[i][j], b_in[i][j]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                if (!rst) begin
                    a_q[i][j]   <= '0;
                    b_q[i][j]   <= '0;
                    acc_q[i][j] <= '0;
                end else begin
                    a_q[i][j]   <= a_in[i][j];
                    b_q[i][j]   <= b_in[i][j];
                    acc_q[i][j] <= acc_d[i][j];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            for (int j = 0; j < int'(N); j++) begin
                bus.c[i][j] = acc_q[i][j];
            end
        end
    end

endmodule

// File: tb/tb_mpu_buffer.sv
// Self-checking bench for mpu_buffer: directed single-PE table, 3x3 skewed product,
// propagation latency, mid-operation reset, and randomized traffic against a reference
// model that sums a[i](n-j) * b[j](n-i) over sampled input history.
module tb_mpu_buffer;
    localparam int unsigned N  = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned OW = 17;
    localparam longint MASK = (longint'(1) << OW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mpu_buffer_if #(.N(N), .DW(DW), .OW(OW)) bus ();
    mpu_buffer #(.N(N), .DW(DW), .OW(OW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: expected accumulators and the last N input samples.
    longint        exp_c  [N][N];
    logic [DW-1:0] hist_a [N][N];   // [sample slot][row]
    logic [DW-1:0] hist_b [N][N];   // [sample slot][column]
    int            t_since = 0;

    function automatic longint mul(input logic [DW-1:0] x, input logic [DW-1:0] y);
`ifdef MPU_BUFFER_SIGNED_EN
        return longint'($signed(x)) * longint'($signed(y));
`else
        return longint'(x) * longint'(y);
`endif
    endfunction

    task automatic model_edge();
        if (!rst) begin
            for (int i = 0; i < int'(N); i++)
                for (int j = 0; j < int'(N); j++) exp_c[i][j] = 0;
            t_since = 0;
        end else begin
            for (int k = 0; k < int'(N); k++) begin
                hist_a[t_since % N][k] = bus.a[k];
                hist_b[t_since % N][k] = bus.b[k];
            end
            for (int i = 0; i < int'(N); i++) begin
                for (int j = 0; j < int'(N); j++) begin
                    if (t_since >= j && t_since >= i) begin
                        exp_c[i][j] = (exp_c[i][j] + mul(hist_a[(t_since - j) % N][i],
                                                         hist_b[(t_since - i) % N][j])) & MASK;
                    end
                end
            end
            t_since++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_zero();
        for (int k = 0; k < int'(N); k++) begin
            bus.a[k] = '0;
            bus.b[k] = '0;
        end
    endtask

    task automatic check_val(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string name);
        int bi = -1, bj = -1;
        for (int i = 0; i < int'(N); i++)
            for (int j = 0; j < int'(N); j++)
                if (bi < 0 && longint'(bus.c[i][j]) != exp_c[i][j]) begin
                    bi = i;
                    bj = j;
                end
        n_checks++;
        if (bi >= 0) begin
            n_fail++;
            $display("FAIL %s: c[%0d][%0d] got %0d, expected %0d", name, bi, bj,
                     bus.c[bi][bj], exp_c[bi][bj]);
        end
    endtask

    task automatic check_all_zero(input string name);
        int bi = -1, bj = -1;
        for (int i = 0; i < int'(N); i++)
            for (int j = 0; j < int'(N); j++)
                if (bi < 0 && bus.c[i][j] != '0) begin
                    bi = i;
                    bj = j;
                end
        n_checks++;
        if (bi >= 0) begin
            n_fail++;
            $display("FAIL %s: c[%0d][%0d] got %0d, expected 0", name, bi, bj, bus.c[bi][bj]);
        end
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            bus.a[k] = DW'($urandom);
            bus.b[k] = DW'($urandom);
        end
        repeat (cycles) tick();
        rst = 1'b1;
        set_zero();
    endtask

    // Single-PE directed cases: a[0], b[0] held for some cycles, result lands in c[0][0].
    typedef struct {
        string         name;
        logic [DW-1:0] a0;
        logic [DW-1:0] b0;
        int            cycles;
        longint        exp00;
    } vec_t;
    vec_t vecs [6];

    typedef struct {
        logic [DW-1:0] a [3];
        logic [DW-1:0] b [3];
    } stim_t;
    stim_t  stim [5];
    longint res3 [3][3];

    task automatic apply_stim(input int r);
        set_zero();
        for (int k = 0; k < 3; k++) begin
            bus.a[k] = stim[r].a[k];
            bus.b[k] = stim[r].b[k];
        end
    endtask

    task automatic check_3x3(input string name);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                check_val($sformatf("%s c[%0d][%0d]", name, i, j), longint'(bus.c[i][j]),
                          res3[i][j]);
        check_model({name, " others"});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef MPU_BUFFER_SIGNED_EN
        vecs[0] = '{"wrap",   8'd255, 8'd255, 3, 3};
        vecs[1] = '{"neg",    8'hFF,  8'd2,   1, 131070};
        vecs[2] = '{"mixed",  8'd100, 8'd200, 2, 119872};
`else
        vecs[0] = '{"wrap",   8'd255, 8'd255, 3, 64003};
        vecs[1] = '{"neg",    8'hFF,  8'd2,   1, 510};
        vecs[2] = '{"mixed",  8'd100, 8'd200, 2, 40000};
`endif
        vecs[3] = '{"small",  8'd3,   8'd4,   5, 60};
        vecs[4] = '{"a_zero", 8'd0,   8'd200, 4, 0};
        vecs[5] = '{"min128", 8'd128, 8'd128, 1, 16384};

        stim[0] = '{'{8'd1, 8'd0, 8'd0}, '{8'd10, 8'd0,  8'd0}};
        stim[1] = '{'{8'd4, 8'd2, 8'd0}, '{8'd11, 8'd13, 8'd0}};
        stim[2] = '{'{8'd7, 8'd5, 8'd3}, '{8'd12, 8'd14, 8'd16}};
        stim[3] = '{'{8'd0, 8'd8, 8'd6}, '{8'd0,  8'd15, 8'd17}};
        stim[4] = '{'{8'd0, 8'd0, 8'd9}, '{8'd0,  8'd0,  8'd18}};
        res3 = '{'{138, 174, 210}, '{171, 216, 261}, '{204, 258, 312}};

        set_zero();

        // Reset with live inputs, then idle release.
        do_reset(2);
        check_all_zero("reset");
        tick();
        check_all_zero("release_1");
        repeat (4) tick();
        check_all_zero("release_5");

        // Directed single-PE table.
        for (int v = 0; v < 6; v++) begin
            do_reset(1);
            bus.a[0] = vecs[v].a0;
            bus.b[0] = vecs[v].b0;
            repeat (vecs[v].cycles) tick();
            set_zero();
            repeat (3) tick();
            check_val({vecs[v].name, " c00"}, longint'(bus.c[0][0]), vecs[v].exp00);
            check_model({vecs[v].name, " model"});
        end

        // 3x3 skewed product.
        do_reset(1);
        for (int r = 0; r < 5; r++) begin
            apply_stim(r);
            tick();
        end
        set_zero();
        repeat (3) tick();
        check_3x3("mm3");
        repeat (10) tick();
        check_3x3("mm3_hold");

        // Corner PE latency: a[7], b[7] pulse reaches PE(7,7) after 7 edges.
        do_reset(1);
        bus.a[7] = 8'd1;
        bus.b[7] = 8'd1;
        tick();
        set_zero();
        repeat (6) tick();
        check_val("lat_early c77", longint'(bus.c[7][7]), 0);
        tick();
        check_val("lat c77", longint'(bus.c[7][7]), 1);
        check_model("lat model");

        // Reset mid-operation.
        do_reset(1);
        for (int r = 0; r < 3; r++) begin
            apply_stim(r);
            tick();
        end
        set_zero();
        rst = 1'b0;
        tick();
        check_all_zero("midrst");
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_all_zero($sformatf("midrst_hold%0d", k));
        end

        // Randomized traffic with occasional resets and idle bursts.
        do_reset(1);
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) != 0);
            for (int k = 0; k < int'(N); k++) begin
                bus.a[k] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
                bus.b[k] = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
            end
            tick();
            check_model($sformatf("rand%0d", n));
        end
        rst = 1'b1;
        set_zero();
        repeat (3 * N) tick();
        check_model("rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mpu_buffer.md
Name: mpu_buffer

Overview:
- Output-stationary N x N systolic multiply-accumulate array: the compute core of the int8 matrix processing unit.
- Upstream logic streams row i of A into port a[i] and column j of B into port b[j], each skewed by one cycle per index.
- Every processing element (PE) keeps its own running sum; c[i][j] exposes that accumulator directly.
- The array contains no control FSM. Accumulators clear only on reset.

Parameters:
- N, 8, array dimension (rows = columns = N).
- DW, 8, operand width of a and b.
- OW, 17, accumulator/output width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset (0 = reset).
- a  input  DW x N (unpacked [0:N-1])  left-edge operand for row i.
- b  input  DW x N (unpacked [0:N-1])  top-edge operand for column j.
- c  output  OW x N x N (unpacked [0:N-1][0:N-1])  accumulator of PE(i,j), registered.

Behaviour:
- Each PE(i,j) has three registers:
  - a_r[i][j], DW bits: operand forwarded right.
  - b_r[i][j], DW bits: operand forwarded down.
  - acc[i][j], OW bits.
- PE inputs:
  - a_in(i,j) = a[i] when j=0, else a_r[i][j-1].
  - b_in(i,j) = b[j] when i=0, else b_r[i-1][j].
- Each rising edge with rst=1:
  - a_r <= a_in.
  - b_r <= b_in.
  - acc <= acc + a_in*b_in.
- c[i][j] = acc[i][j], driven straight from the register with no combinational path from inputs.
- Net timing: acc[i][j] at edge n adds a[i] sampled at edge n-j times b[j] sampled at edge n-i.
- Arithmetic:
  - Operands are unsigned by default.
  - The product is zero-extended to OW.
  - The sum wraps modulo 2^OW. There is no saturation and no overflow flag.
- Latency for a full N x N product:
  - First input edge is k.
  - Last skewed inputs arrive at edge k+2N-2.
  - c[N-1][N-1] is final after edge k+3N-3. For N=8: 22 edges in total, edges k..k+21.
  - PE(i,j) is final after edge k+N-1+i+j.
- Zero inputs add zero, so results hold indefinitely once inputs return to 0.
- Reset (rst=0 at a rising edge) clears all a_r, b_r and acc; every c reads 0 on the next cycle.
  - Reset mid-operation discards all partial sums and in-flight operands.
  - rst=0 has priority over accumulation.
- No handshake: an input is consumed every cycle. Feeding the skew and the zero padding is the caller's responsibility.
- Unused rows/columns fed 0 keep their accumulators at 0.

Optional Feature:
- Macro MPU_BUFFER_SIGNED_EN.
- When defined:
  - a and b are two's-complement int8.
  - Each product is sign-extended to OW before accumulation.
  - acc is two's complement and wraps modulo 2^OW.
- When undefined: unsigned operation as described in Behaviour.
- Reset values and latency are identical in both modes.

Test Plan:
- Reset: hold rst=0 with random a/b for 2 cycles -> every c[i][j]=0. Release with all inputs 0 for 5 cycles -> c stays 0.
- 3x3 skewed product, with one stimulus per cycle after rst goes 1 and remaining ports held 0:
  - Stimulus (a0,a1,a2 / b0,b1,b2):
    - 1,0,0 / 10,0,0
    - 4,2,0 / 11,13,0
    - 7,5,3 / 12,14,16
    - 0,8,6 / 0,15,17
    - 0,0,9 / 0,0,18
    - then zeros.
  - Required results:
    - Row 0: c[0][0]=138, c[0][1]=174, c[0][2]=210.
    - Row 1: c[1][0]=171, c[1][1]=216, c[1][2]=261.
    - Row 2: c[2][0]=204, c[2][1]=258, c[2][2]=312.
  - All other c = 0. Values are stable from 3 cycles after the last nonzero input onward.
- Propagation latency: single pulse a[7]=1, b[7]=1 (with skew: a[7] and b[7] at the same edge) -> c[7][7]=1 exactly 7 edges later. All other c = 0.
- Wrap: a[0]=255, b[0]=255 for 3 cycles -> c[0][0]=195075 mod 131072 = 64003.
- Reset mid-operation: run the 3x3 case, assert rst=0 one cycle after the third stimulus, then release with zeros -> all c = 0 and stay 0.
- With MPU_BUFFER_SIGNED_EN: a[0]=8'hFF (-1), b[0]=2 for one cycle -> c[0][0]=17'h1FFFE (-2). Without the macro, the same stimulus gives 510.
